// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD controller: state encoding,
// datapath select codes, register indices and the per-state control decode.
package gcd_pkg;

  // Controller states. Encodings 9..15 are unreachable and recover to IDLE.
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LOAD_X  = 4'd1,
    LOAD_Y  = 4'd2,
    CHECK   = 4'd3,
    COMPARE = 4'd4,
    SUB_AB  = 4'd5,
    SUB_BA  = 4'd6,
    DONE    = 4'd7,
    FAIL    = 4'd8
  } state_t;

  // Register-file data-in mux selects.
  localparam logic [1:0] IN_SEL_X   = 2'b00;
  localparam logic [1:0] IN_SEL_Y   = 2'b01;
  localparam logic [1:0] IN_SEL_ALU = 2'b10;

  // ALU operation selects.
  localparam logic ALU_A_MINUS_B = 1'b0;
  localparam logic ALU_B_MINUS_A = 1'b1;

  // Register indices holding the two operands; R0 also holds the result.
  localparam logic [1:0] REG_X = 2'd0;
  localparam logic [1:0] REG_Y = 2'd1;

  // Full set of Moore outputs produced for one state.
  typedef struct packed {
    logic       we;
    logic [2:0] wa;
    logic       rae;
    logic [1:0] raa;
    logic       rbe;
    logic [1:0] rba;
    logic [1:0] in_sel;
    logic       alu_op;
    logic       ready;
    logic       done;
    logic       err;
  } ctrl_t;

  // Map a state to its control outputs. Everything defaults to inactive so
  // that WE can only be raised by the four writing states.
  function automatic ctrl_t ctrl_decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      IDLE: begin
        c.ready = 1'b1;
      end
      LOAD_X: begin
        c.we     = 1'b1;
        c.wa     = {1'b0, REG_X};
        c.in_sel = IN_SEL_X;
      end
      LOAD_Y: begin
        c.we     = 1'b1;
        c.wa     = {1'b0, REG_Y};
        c.in_sel = IN_SEL_Y;
      end
      CHECK, COMPARE: begin
        c.rae = 1'b1;
        c.raa = REG_X;
        c.rbe = 1'b1;
        c.rba = REG_Y;
      end
      SUB_AB: begin
        c.rae    = 1'b1;
        c.raa    = REG_X;
        c.rbe    = 1'b1;
        c.rba    = REG_Y;
        c.alu_op = ALU_A_MINUS_B;
        c.in_sel = IN_SEL_ALU;
        c.we     = 1'b1;
        c.wa     = {1'b0, REG_X};
      end
      SUB_BA: begin
        c.rae    = 1'b1;
        c.raa    = REG_X;
        c.rbe    = 1'b1;
        c.rba    = REG_Y;
        c.alu_op = ALU_B_MINUS_A;
        c.in_sel = IN_SEL_ALU;
        c.we     = 1'b1;
        c.wa     = {1'b0, REG_Y};
      end
      DONE: begin
        c.rae  = 1'b1;
        c.raa  = REG_X;
        c.done = 1'b1;
      end
      FAIL: begin
        c.rae  = 1'b1;
        c.raa  = REG_X;
        c.done = 1'b1;
        c.err  = 1'b1;
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/gcd_ctrl.sv
// Control FSM for the subtract-based GCD datapath. Loads x/y into R0/R1,
// then repeatedly subtracts the smaller register from the larger until the
// two are equal, leaving the result in R0. Zero operands or running out of
// iterations end the operation with err.
module gcd_ctrl #(
  parameter int unsigned MAX_ITER = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       eq,
  input  logic       lt,
  input  logic       a_zero,
  input  logic       b_zero,
  output logic       WE,
  output logic [2:0] WA,
  output logic       RAE,
  output logic [1:0] RAA,
  output logic       RBE,
  output logic [1:0] RBA,
  output logic [1:0] in_sel,
  output logic       alu_op,
  output logic       ready,
  output logic       done,
  output logic       err,
  output logic [7:0] iter_count
);

  import gcd_pkg::*;

  localparam logic [7:0] LP_MAX_ITER = MAX_ITER[7:0];

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_iter;
  logic [7:0] w_next_iter;
  ctrl_t      r_ctrl;

  // Next-state and iteration-counter logic.
  always_comb begin
    w_next_state = IDLE;
    w_next_iter  = r_iter;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = LOAD_X;
          w_next_iter  = 8'd0;
        end else begin
          w_next_state = IDLE;
        end
      end
      LOAD_X: begin
        w_next_state = LOAD_Y;
      end
      LOAD_Y: begin
        w_next_state = CHECK;
      end
      CHECK: begin
        if (a_zero || b_zero) begin
          w_next_state = FAIL;
        end else begin
          w_next_state = COMPARE;
        end
      end
      COMPARE: begin
        // Equality wins over the iteration limit: a result reached on the
        // last allowed step is still a success.
        if (eq) begin
          w_next_state = DONE;
        end else if (r_iter == LP_MAX_ITER) begin
          w_next_state = FAIL;
        end else if (lt) begin
          w_next_state = SUB_BA;
        end else begin
          w_next_state = SUB_AB;
        end
      end
      SUB_AB, SUB_BA: begin
        w_next_state = COMPARE;
        if (r_iter == LP_MAX_ITER) begin
          w_next_iter = r_iter;
        end else begin
          w_next_iter = r_iter + 8'd1;
        end
      end
      DONE, FAIL: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State register, counter and registered Moore outputs (decoded from the
  // state being entered so they line up with the registered state).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_iter  <= 8'd0;
      r_ctrl  <= ctrl_decode(IDLE);
    end else begin
      r_state <= w_next_state;
      r_iter  <= w_next_iter;
      r_ctrl  <= ctrl_decode(w_next_state);
    end
  end

  assign WE         = r_ctrl.we;
  assign WA         = r_ctrl.wa;
  assign RAE        = r_ctrl.rae;
  assign RAA        = r_ctrl.raa;
  assign RBE        = r_ctrl.rbe;
  assign RBA        = r_ctrl.rba;
  assign in_sel     = r_ctrl.in_sel;
  assign alu_op     = r_ctrl.alu_op;
  assign ready      = r_ctrl.ready;
  assign done       = r_ctrl.done;
  assign err        = r_ctrl.err;
  assign iter_count = r_iter;

endmodule

// File: tb/tb_gcd_ctrl.sv
// Bench for gcd_ctrl: two controller instances (default MAX_ITER and
// MAX_ITER=3), each paired with a behavioural register file, ALU and
// comparator. Results are checked against a plain arithmetic GCD model.
module tb_gcd_ctrl;

  logic       clk;
  logic       reset;
  logic       start_s  [2];
  logic [7:0] x_s      [2];
  logic [7:0] y_s      [2];
  logic       eq_s     [2];
  logic       lt_s     [2];
  logic       az_s     [2];
  logic       bz_s     [2];
  logic       we_s     [2];
  logic [2:0] wa_s     [2];
  logic       rae_s    [2];
  logic [1:0] raa_s    [2];
  logic       rbe_s    [2];
  logic [1:0] rba_s    [2];
  logic [1:0] insel_s  [2];
  logic       aluop_s  [2];
  logic       ready_s  [2];
  logic       done_s   [2];
  logic       err_s    [2];
  logic [7:0] iter_s   [2];
  logic [7:0] adata_s  [2];

  int n_chk;
  int n_pass;

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0] rf [4];
    logic [7:0] w_a;
    logic [7:0] w_b;
    logic [7:0] w_din;

    assign w_a        = rae_s[g] ? rf[raa_s[g]] : 8'd0;
    assign w_b        = rbe_s[g] ? rf[rba_s[g]] : 8'd0;
    assign adata_s[g] = w_a;
    assign eq_s[g]    = (w_a == w_b);
    assign lt_s[g]    = (w_a < w_b);
    assign az_s[g]    = (w_a == 8'd0);
    assign bz_s[g]    = (w_b == 8'd0);

    // Data-in mux with the behavioural ALU.
    always_comb begin
      case (insel_s[g])
        2'b00:   w_din = x_s[g];
        2'b01:   w_din = y_s[g];
        2'b10:   w_din = aluop_s[g] ? (w_b - w_a) : (w_a - w_b);
        default: w_din = 8'd0;
      endcase
    end

    // Register file write port with its own reset.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < 4; i++) rf[i] <= 8'd0;
      end else if (we_s[g]) begin
        rf[wa_s[g][1:0]] <= w_din;
      end
    end

    gcd_ctrl #(.MAX_ITER(g == 0 ? 255 : 3)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start_s[g]),
      .eq         (eq_s[g]),
      .lt         (lt_s[g]),
      .a_zero     (az_s[g]),
      .b_zero     (bz_s[g]),
      .WE         (we_s[g]),
      .WA         (wa_s[g]),
      .RAE        (rae_s[g]),
      .RAA        (raa_s[g]),
      .RBE        (rbe_s[g]),
      .RBA        (rba_s[g]),
      .in_sel     (insel_s[g]),
      .alu_op     (aluop_s[g]),
      .ready      (ready_s[g]),
      .done       (done_s[g]),
      .err        (err_s[g]),
      .iter_count (iter_s[g])
    );
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Run one operation on instance g and compare against the GCD model.
  // Entered and left #1 after a rising edge. If pulse_mid is set, start is
  // also pulsed mid-run and during the done cycle; both must be ignored.
  task automatic run_op(input int g, input logic [7:0] x, input logic [7:0] y,
                        input bit pulse_mid);
    int unsigned m;
    int unsigned a, b, n;
    int exp_err, exp_cyc, exp_we;
    int cyc, we_cnt, got;
    int got_cyc, got_a, got_err, got_iter;
    m = (g == 0) ? 255 : 3;
    a = x;
    b = y;
    n = 0;
    if (x == 8'd0 || y == 8'd0) begin
      exp_err = 1;
      exp_cyc = 4;
    end else begin
      while (a != b && n < m) begin
        if (a > b) a = a - b;
        else b = b - a;
        n++;
      end
      exp_err = (a != b) ? 1 : 0;
      exp_cyc = 5 + 2 * int'(n);
    end
    exp_we = 2 + int'(n);

    x_s[g]     = x;
    y_s[g]     = y;
    start_s[g] = 1'b1;
    @(posedge clk);
    #1 start_s[g] = 1'b0;
    cyc = 1; we_cnt = 0; got = 0;
    got_cyc = 0; got_a = 0; got_err = 0; got_iter = 0;
    while (cyc < 700 && got == 0) begin
      @(negedge clk);
      if (we_s[g]) we_cnt++;
      if (done_s[g]) begin
        got = 1;
        got_cyc = cyc; got_a = adata_s[g]; got_err = err_s[g]; got_iter = iter_s[g];
        if (pulse_mid) start_s[g] = 1'b1;
      end else begin
        if (pulse_mid && cyc == 6) start_s[g] = 1'b1;
        @(posedge clk);
        #1 start_s[g] = 1'b0;
        cyc++;
      end
    end
    if (got == 0) begin
      check_val("done_timeout", 0, 1);
    end else begin
      check_val("done_cycle", got_cyc, exp_cyc);
      check_val("result_a", got_a, int'(a));
      check_val("err", got_err, exp_err);
      check_val("iter_count", got_iter, int'(n));
      check_val("we_writes", we_cnt, exp_we);
      @(posedge clk);
      #1 start_s[g] = 1'b0;
      @(negedge clk);
      check_val("ready_after", ready_s[g], 1);
      check_val("done_after", done_s[g], 0);
      check_val("iter_hold", iter_s[g], int'(n));
      if (pulse_mid) begin
        @(negedge clk);
        check_val("start_in_done_ignored", ready_s[g], 1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Main stimulus sequence.
  initial begin
    n_chk  = 0;
    n_pass = 0;
    reset  = 1'b1;
    for (int g = 0; g < 2; g++) begin
      start_s[g] = 1'b0;
      x_s[g]     = 8'd0;
      y_s[g]     = 8'd0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check_val("rst_ready", ready_s[g], 1);
      check_val("rst_err", err_s[g], 0);
      check_val("rst_iter", iter_s[g], 0);
    end
    @(posedge clk);
    #1 reset = 1'b0;

    // Idle with start low.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("idle_ready", ready_s[0], 1);
      check_val("idle_we", we_s[0], 0);
      check_val("idle_done", done_s[0], 0);
      @(posedge clk);
      #1;
    end

    // Directed cases.
    run_op(0, 8'd12,  8'd8,  1'b0);
    run_op(0, 8'd12,  8'd12, 1'b0);
    run_op(0, 8'd255, 8'd1,  1'b0);
    run_op(0, 8'd0,   8'd7,  1'b0);
    run_op(0, 8'd7,   8'd0,  1'b0);
    run_op(1, 8'd200, 8'd1,  1'b1);
    run_op(1, 8'd12,  8'd8,  1'b0);
    run_op(1, 8'd5,   8'd1,  1'b0);
    run_op(0, 8'd1,   8'd255, 1'b1);

    // Reset in cycle 6 of a 48/18 run, then rerun.
    x_s[0]     = 8'd48;
    y_s[0]     = 8'd18;
    start_s[0] = 1'b1;
    @(posedge clk);
    #1 start_s[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_val("pre_reset_busy", ready_s[0], 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_val("post_reset_ready", ready_s[0], 1);
    check_val("post_reset_we", we_s[0], 0);
    @(posedge clk);
    #1;
    run_op(0, 8'd48, 8'd18, 1'b0);

    // Randomised operands on both instances.
    for (int i = 0; i < 24; i++) begin
      logic [7:0] rx, ry;
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(1, 255));
      if (i % 8 == 7) rx = 8'd0;
      run_op(i % 3 == 2 ? 1 : 0, rx, ry, (i % 5 == 0) ? 1'b1 : 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
